shift_down_ctrl: RTL

Sequencer and arbiter at the head of the SHIFTDN chain, whose stage 0 is SMC_ID 0 and whose stages are ordered by ascending SMC_ID.
- Accepts SHIFTDN write requests from NUM_REQ requesters and arbitrates between them round-robin.
- Drives one 134-bit crd_shiftdn word (vld + 128b data + 5b smc_id) into stage 0.
- Waits the chain's per-stage register latency until the target stage has captured, then signals per-requester completion.
- Keeps exactly one instruction in flight, because a chain stage holds its last word when its input valid is low.

---
 rtl/shift_down_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/shift_down_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/shift_down_pkg.sv
// Shared constants, crd word layout and FSM states
// for the SHIFTDN chain head controller.
package shift_down_pkg;

    localparam int CRD_W  = 134;
    localparam int DATA_W = 128;
    localparam int ID_W   = 5;

    localparam int CRD_VLD_BIT  = 133;
    localparam int CRD_DATA_MSB = 132;
    localparam int CRD_DATA_LSB = 5;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        ERR
    } state_e;

    function automatic logic [CRD_W-1:0] crd_pack(
        input logic              vld,
        input logic [DATA_W-1:0] data,
        input logic [ID_W-1:0]   id
    );
        return {vld, data, id};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request
// at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    // scan from the pointer, first hit wins
    always_comb begin
        int   pos;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = PW'(pos);
            end
        end
    end

endmodule

// File: rtl/shift_down_ctrl.sv
// Head-of-chain sequencer: arbitrates SHIFTDN writes,
// issues one crd word and waits for the target stage.
module shift_down_ctrl
    import shift_down_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NUM_SMC = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_vld,
    output logic [NUM_REQ-1:0]        req_rdy,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*ID_W-1:0]   req_smc_id,
    output logic [NUM_REQ-1:0]        rsp_vld,
    output logic                      rsp_err,
    output logic [CRD_W-1:0]          crd_shiftdn_out,
    output logic                      busy,
    output logic [15:0]               issue_cnt
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ID_W:0] SMC_LIM = (ID_W+1)'(NUM_SMC);
    localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

    state_e              state_q;
    state_e              state_d;
    logic [PW-1:0]       ptr_q;
    logic [PW-1:0]       sel_q;
    logic [CRD_W-1:0]    crd_q;
    logic [ID_W-1:0]     cnt_q;
    logic [15:0]         issue_q;

    logic [NUM_REQ-1:0]  gnt;
    logic [PW-1:0]       gidx;
    logic                accept;
    logic                legal;
    logic [DATA_W-1:0]   acc_data;
    logic [ID_W-1:0]     acc_id;
    logic [PW-1:0]       ptr_nxt;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req (req_vld),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gidx)
    );

    // grant is only offered while idle and out of reset
    always_comb begin
        req_rdy  = '0;
        if (state_q == IDLE && !rst) begin
            req_rdy = gnt;
        end
        accept   = |(req_vld & req_rdy);
        acc_data = req_data[gidx*DATA_W +: DATA_W];
        acc_id   = req_smc_id[gidx*ID_W +: ID_W];
        legal    = {1'b0, acc_id} < SMC_LIM;
        ptr_nxt  = (gidx == LAST) ? '0 : gidx + 1'b1;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and per-state outputs
    always_comb begin
        state_d = state_q;
        rsp_vld = '0;
        rsp_err = 1'b0;
        busy    = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = legal ? ISSUE : ERR;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_vld[sel_q] = 1'b1;
                state_d        = IDLE;
            end
            ERR: begin
                rsp_vld[sel_q] = 1'b1;
                rsp_err        = 1'b1;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // crd word, wait counter, pointer and issue count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            sel_q   <= '0;
            crd_q   <= '0;
            cnt_q   <= '0;
            issue_q <= '0;
        end else if (accept) begin
            ptr_q <= ptr_nxt;
            sel_q <= gidx;
            if (legal) begin
                crd_q   <= crd_pack(1'b1, acc_data, acc_id);
                issue_q <= issue_q + 16'd1;
            end
        end else if (state_q == ISSUE) begin
            crd_q[CRD_VLD_BIT] <= 1'b0;
            cnt_q              <= crd_q[ID_W-1:0];
        end else if (state_q == WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign crd_shiftdn_out = crd_q;
    assign issue_cnt       = issue_q;

endmodule
